// File: rtl/plot_arb_pkg.sv
// plot_arb_pkg: shared state encodings, pixel field widths and watchdog default for plot_arbiter.
package plot_arb_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;
  localparam int WDOG_CYCLES_DEF = 1024;
  function automatic logic [1:0] own_state(input logic n);
    return n ? OWN1 : OWN0;
  endfunction
endpackage

// File: rtl/plot_arb_wdog.sv
// plot_arb_wdog: idle-cycle counter that fires when an owner goes WDOG_CYCLES cycles without progress.
module plot_arb_wdog
  import plot_arb_pkg::*;
#(
  parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic clr,
  output logic fire
);
  localparam int CW = WDOG_CYCLES > 2 ? $clog2(WDOG_CYCLES) : 1;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    fire = active & ~clr & (count_q == CW'(WDOG_CYCLES - 1));
    count_d = (~active | clr | fire) ? '0 : count_q + CW'(1);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: rtl/plot_arbiter.sv
// plot_arbiter: two-requester round-robin arbiter for a shared VGA plot port.
// Define PLOT_ARBITER_WATCHDOG_EN to add a forced release after WDOG_CYCLES idle owned cycles.
module plot_arbiter
  import plot_arb_pkg::*;
`ifdef PLOT_ARBITER_WATCHDOG_EN
#(
  parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
)
`endif
(
  input  logic           clk,
  input  logic           reset,
  input  logic           req0,
  input  logic           req1,
  input  logic [X_W-1:0] x0,
  input  logic [X_W-1:0] x1,
  input  logic [Y_W-1:0] y0,
  input  logic [Y_W-1:0] y1,
  input  logic [C_W-1:0] colour0,
  input  logic [C_W-1:0] colour1,
  input  logic           plot0,
  input  logic           plot1,
  input  logic           last0,
  input  logic           last1,
  output logic           gnt0,
  output logic           gnt1,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [C_W-1:0] vga_colour,
  output logic           vga_plot,
  output logic           wdog_fire
);
  logic [1:0] state_q, state_d;
  logic last_served_q, last_served_d;
  logic [X_W-1:0] vga_x_q, vga_x_d;
  logic [Y_W-1:0] vga_y_q, vga_y_d;
  logic [C_W-1:0] vga_colour_q, vga_colour_d;
  logic vga_plot_q, vga_plot_d;
  logic acc0, acc1, owner, rel_req, fire;
  always_comb begin
    acc0 = plot0 & (state_q == OWN0);
    acc1 = plot1 & (state_q == OWN1);
    owner = state_q == OWN1;
    // voluntary release: final pixel accepted, or the owner dropped its request
    rel_req = (acc0 & last0) | (acc1 & last1) | ((state_q == OWN0) & ~req0) | ((state_q == OWN1) & ~req1);
    state_d = state_q;
    last_served_d = last_served_q;
    if (state_q == IDLE)
      state_d = (req0 & req1) ? own_state(~last_served_q) : req0 ? OWN0 : req1 ? OWN1 : IDLE;
    else if (rel_req | fire) begin
      state_d = (owner ? req0 : req1) ? own_state(~owner) : IDLE;
      last_served_d = owner;
    end
    vga_plot_d = acc0 | acc1;
    vga_x_d = acc1 ? x1 : acc0 ? x0 : vga_x_q;
    vga_y_d = acc1 ? y1 : acc0 ? y0 : vga_y_q;
    vga_colour_d = acc1 ? colour1 : acc0 ? colour0 : vga_colour_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      last_served_q <= 1'b1;
      vga_x_q <= '0;
      vga_y_q <= '0;
      vga_colour_q <= '0;
      vga_plot_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_served_q <= last_served_d;
      vga_x_q <= vga_x_d;
      vga_y_q <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q <= vga_plot_d;
    end
`ifdef PLOT_ARBITER_WATCHDOG_EN
  logic wdog_fire_q;
  plot_arb_wdog #(.WDOG_CYCLES(WDOG_CYCLES)) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .active (state_q != IDLE),
    .clr    (acc0 | acc1 | rel_req),
    .fire   (fire)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) wdog_fire_q <= 1'b0;
    else wdog_fire_q <= fire;
  assign wdog_fire = wdog_fire_q;
`else
  assign fire = 1'b0;
  assign wdog_fire = 1'b0;
`endif
  assign gnt0 = state_q == OWN0;
  assign gnt1 = state_q == OWN1;
  assign vga_x = vga_x_q;
  assign vga_y = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot = vga_plot_q;
endmodule

// File: tb/tb_plot_arbiter.sv
// tb_plot_arbiter: directed and random stimulus checked against a behavioural owner/queue model.
module tb_plot_arbiter;
  localparam int WD = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0 = 0, req1 = 0, plot0 = 0, plot1 = 0, last0 = 0, last1 = 0;
  logic [7:0] x0 = 0, x1 = 0;
  logic [6:0] y0 = 0, y1 = 0;
  logic [2:0] colour0 = 0, colour1 = 0;
  logic gnt0, gnt1, vga_plot, wdog_fire;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  int n_chk = 0, n_pass = 0;
  int m_own, m_ls, m_cnt;
  bit m_vp, m_wf;
  logic [7:0] m_vx;
  logic [6:0] m_vy;
  logic [2:0] m_vc;
  int order[$];

  always #5 clk = ~clk;

`ifdef PLOT_ARBITER_WATCHDOG_EN
  plot_arbiter #(.WDOG_CYCLES(WD)) dut (
`else
  plot_arbiter dut (
`endif
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .colour0(colour0), .colour1(colour1), .plot0(plot0), .plot1(plot1), .last0(last0), .last1(last1),
    .gnt0(gnt0), .gnt1(gnt1), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .wdog_fire(wdog_fire));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] obs_pack();
    return 32'({gnt0, gnt1, vga_plot, wdog_fire, vga_x, vga_y, vga_colour});
  endfunction

  function automatic logic [31:0] exp_pack();
    return 32'({m_own == 0, m_own == 1, m_vp, m_wf, m_vx, m_vy, m_vc});
  endfunction

  task automatic model_reset();
    m_own = -1; m_ls = 1; m_cnt = 0; m_vp = 0; m_wf = 0; m_vx = 0; m_vy = 0; m_vc = 0;
  endtask

  task automatic model_step();
    bit rq[2], pl[2], la[2];
    bit acc, rel, fire;
    int n;
    rq[0] = req0; rq[1] = req1; pl[0] = plot0; pl[1] = plot1; la[0] = last0; la[1] = last1;
    fire = 0;
    m_vp = 0; m_wf = 0;
    if (m_own < 0) begin
      if (req0 && req1) m_own = (m_ls == 1) ? 0 : 1;
      else if (req0) m_own = 0;
      else if (req1) m_own = 1;
      m_cnt = 0;
    end else begin
      n = m_own;
      acc = pl[n];
      m_vp = acc;
      if (acc) begin
        m_vx = n ? x1 : x0; m_vy = n ? y1 : y0; m_vc = n ? colour1 : colour0;
      end
      rel = (acc && la[n]) || !rq[n];
      m_cnt = acc ? 0 : m_cnt + 1;
`ifdef PLOT_ARBITER_WATCHDOG_EN
      fire = !rel && m_cnt == WD;
`endif
      m_wf = fire;
      if (rel || fire) begin
        m_ls = n;
        m_own = rq[1 - n] ? 1 - n : -1;
        m_cnt = 0;
      end
    end
  endtask

  task automatic clear_in();
    req0 = 0; req1 = 0; plot0 = 0; plot1 = 0; last0 = 0; last1 = 0;
  endtask

  task automatic cyc(input string tag);
    model_step();
    @(posedge clk);
    @(negedge clk);
    check(tag, obs_pack(), exp_pack());
    if (gnt0 && gnt1) check("mutex", 32'(gnt0 & gnt1), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1;
    clear_in();
    #1 check("rst_now", obs_pack(), 0);
    model_reset();
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_init", obs_pack(), 0);
    reset = 0;
    // single burst of four pixels
    req0 = 1; cyc("b_req");
    check("b_gnt0", 32'(gnt0), 1);
    for (int i = 0; i < 4; i++) begin
      plot0 = 1; x0 = 8'(50 + i); y0 = 60; colour0 = 7; last0 = (i == 3);
      cyc("b_pix");
      check("b_vx", 32'({vga_plot, vga_x}), 32'({1'b1, 8'(50 + i)}));
    end
    check("b_idle", 32'({gnt0, gnt1}), 0);
    clear_in(); cyc("b_end");
    // contention from reset: 0 first, then 1 with no idle bubble
    do_reset();
    req0 = 1; req1 = 1; cyc("c_req");
    check("c_gnt0", 32'({gnt0, gnt1}), 32'(2'b10));
    plot0 = 1; last0 = 1; x0 = 5; cyc("c_last");
    check("c_gnt1", 32'({gnt0, gnt1}), 32'(2'b01));
    // fairness: three single-pixel bursts each
    do_reset();
    req0 = 1; req1 = 1; plot0 = 0; last0 = 0; cyc("f_req");
    order.delete();
    for (int i = 0; i < 6; i++) begin
      order.push_back(gnt1 ? 1 : gnt0 ? 0 : -1);
      plot0 = gnt0; last0 = gnt0; plot1 = gnt1; last1 = gnt1; x0 = 8'(i); x1 = 8'(100 + i);
      cyc("f_pix");
    end
    for (int i = 0; i < 6; i++) check("f_order", 32'(order[i]), 32'(i % 2));
    // ignored plot from the non-owner
    do_reset();
    req0 = 1; cyc("i_req");
    plot1 = 1; x1 = 10; y1 = 3;
    for (int i = 0; i < 3; i++) begin
      cyc("i_cyc");
      check("i_nox10", 32'(vga_plot && vga_x == 10), 0);
    end
    plot0 = 1; last0 = 1; x0 = 20; cyc("i_own");
    check("i_vx", 32'(vga_x), 20);
    clear_in(); cyc("i_end");
    // abort by dropping the request
    req0 = 1; cyc("a_req");
    plot0 = 1; x0 = 33; cyc("a_pix");
    req0 = 0; plot0 = 0; cyc("a_drop");
    check("a_gnt0", 32'(gnt0), 0);
    // reset mid-burst, then first grant right after
    req0 = 1; cyc("r_req");
    plot0 = 1; x0 = 77; cyc("r_pix");
    do_reset();
    cyc("r_after");
    check("r_noplot", 32'(vga_plot), 0);
    req1 = 1; cyc("r_first");
    check("r_gnt1", 32'(gnt1), 1);
`ifdef PLOT_ARBITER_WATCHDOG_EN
    do_reset();
    req1 = 1; cyc("w_req");
    req0 = 1;
    for (int i = 0; i < WD; i++) cyc("w_hold");
    check("w_fire", 32'({wdog_fire, gnt1, gnt0}), 32'(3'b101));
    cyc("w_after");
    check("w_pulse", 32'(wdog_fire), 0);
`endif
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      req0 = $urandom_range(0, 4) != 0; req1 = $urandom_range(0, 4) != 0;
      plot0 = $urandom_range(0, 2) == 0; plot1 = $urandom_range(0, 2) == 0;
      last0 = $urandom_range(0, 3) == 0; last1 = $urandom_range(0, 3) == 0;
      x0 = 8'($urandom_range(0, 159)); x1 = 8'($urandom_range(0, 159));
      y0 = 7'($urandom_range(0, 119)); y1 = 7'($urandom_range(0, 119));
      colour0 = 3'($urandom); colour1 = 3'($urandom);
      cyc("rand");
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
